// File: rtl/bus_if_types_pkg.sv
// Shared bus transfer types used by the core's masters and slaves,
// plus the state encoding of the dual-master arbiter.
package bus_if_types_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } tsize_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_I = 2'b01,
    OWN_D = 2'b10
  } arb_state_e;

  // Tie-break: fixed priority always favours data; round robin follows ptr_d.
  function automatic arb_state_e arb_pick(input logic rr, input logic ptr_d,
                                          input logic i_req, input logic d_req);
    arb_state_e pick;
    pick = IDLE;
    if (i_req && d_req) pick = (rr && !ptr_d) ? OWN_I : OWN_D;
    else if (d_req)     pick = OWN_D;
    else if (i_req)     pick = OWN_I;
    return pick;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Counts cycles an active transfer waits for completion and flags expiry.
// TIMEOUT_CYCLES = 0 disables the watchdog entirely.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic done,
  output logic expired
);

  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt;

  // cnt holds the number of completed waiting cycles, so the current cycle is cnt+1.
  assign expired = ENABLED && start && !done && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!start || done || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dual_master_bus_arbiter.sv
// Merges the instruction and data bus masters onto one slave port, one
// transfer at a time, with a watchdog that terminates hung transfers.
module dual_master_bus_arbiter
  import bus_if_types_pkg::*;
#(
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_breq,
  input  ttype_e      i_ttype,
  input  tsize_e      i_tsize,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] i_rdata,
  output logic        i_bdone,
  input  logic        d_breq,
  input  ttype_e      d_ttype,
  input  tsize_e      d_tsize,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_bdone,
  output logic        s_bstart,
  output logic        s_breq,
  output ttype_e      s_ttype,
  output tsize_e      s_tsize,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_bdone,
  output logic        timeout_err
);

  arb_state_e state, state_nxt;
  logic       ptr_d;
  logic       own_i, own_d;
  logic       expired;
  logic       xfer_end;

  assign own_i    = (state == OWN_I);
  assign own_d    = (state == OWN_D);
  assign s_bstart = own_i | own_d;
  assign s_breq   = s_bstart;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (s_bstart),
    .done   (s_bdone),
    .expired(expired)
  );

  assign xfer_end    = s_bstart && (s_bdone || expired);
  assign timeout_err = expired;

  // The finishing master's breq still describes the transfer just completed,
  // so it is masked; only the other master can take the bus without a bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = arb_pick(ROUND_ROBIN, ptr_d, i_breq, d_breq);
      OWN_I: if (xfer_end) state_nxt = s_bdone ? arb_pick(ROUND_ROBIN, ptr_d, 1'b0, d_breq) : IDLE;
      OWN_D: if (xfer_end) state_nxt = s_bdone ? arb_pick(ROUND_ROBIN, ptr_d, i_breq, 1'b0) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr_d <= 1'b1;
    end else begin
      state <= state_nxt;
      if (ROUND_ROBIN && xfer_end) ptr_d <= own_i;
    end
  end

  always_comb begin
    s_ttype = READ;
    s_tsize = WORD;
    s_addr  = '0;
    s_wdata = '0;
    case (state)
      OWN_I: begin
        s_ttype = i_ttype;
        s_tsize = i_tsize;
        s_addr  = i_addr;
        s_wdata = i_wdata;
      end
      OWN_D: begin
        s_ttype = d_ttype;
        s_tsize = d_tsize;
        s_addr  = d_addr;
        s_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  assign i_bdone = own_i && (s_bdone || expired);
  assign d_bdone = own_d && (s_bdone || expired);
  assign i_rdata = (own_i && s_bdone) ? s_rdata : '0;
  assign d_rdata = (own_d && s_bdone) ? s_rdata : '0;

`ifndef SYNTHESIS
  // A master must keep its request and fields steady until it sees bdone.
  a_i_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (i_breq && !i_bdone) |=> (i_breq && $stable({i_ttype, i_tsize, i_addr, i_wdata})));
  a_d_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (d_breq && !d_bdone) |=> (d_breq && $stable({d_ttype, d_tsize, d_addr, d_wdata})));
`endif

endmodule

// File: tb/tb_dual_master_bus_arbiter.sv
// Scoreboard bench: one round-robin and one fixed-priority arbiter share the
// master stimulus; a slave model answers whichever instance is selected.
module tb_dual_master_bus_arbiter;
  import bus_if_types_pkg::*;

  localparam logic [31:0] RKEY = 32'hDEADBEEF ^ 32'h0000_0100;

  logic clk, rst_n, sel;
  logic i_breq, d_breq, s_bdone;
  ttype_e i_ttype, d_ttype;
  tsize_e i_tsize, d_tsize;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, s_rdata;

  logic rr_ib, rr_db, rr_bstart, rr_breq, rr_to, fp_ib, fp_db, fp_bstart, fp_breq, fp_to;
  logic [31:0] rr_ir, rr_dr, rr_addr, rr_wdata, fp_ir, fp_dr, fp_addr, fp_wdata;
  ttype_e rr_ttype, fp_ttype;
  tsize_e rr_tsize, fp_tsize;
  logic rr_ireq, rr_dreq, fp_ireq, fp_dreq;

  assign rr_ireq = i_breq & ~sel;
  assign rr_dreq = d_breq & ~sel;
  assign fp_ireq = i_breq & sel;
  assign fp_dreq = d_breq & sel;

  logic m_ib, m_db, m_bstart, m_breq, m_to;
  logic [31:0] m_ir, m_dr, m_addr, m_wdata;
  ttype_e m_ttype;
  tsize_e m_tsize;
  assign m_ib     = sel ? fp_ib     : rr_ib;
  assign m_db     = sel ? fp_db     : rr_db;
  assign m_bstart = sel ? fp_bstart : rr_bstart;
  assign m_breq   = sel ? fp_breq   : rr_breq;
  assign m_to     = sel ? fp_to     : rr_to;
  assign m_ir     = sel ? fp_ir     : rr_ir;
  assign m_dr     = sel ? fp_dr     : rr_dr;
  assign m_addr   = sel ? fp_addr   : rr_addr;
  assign m_wdata  = sel ? fp_wdata  : rr_wdata;
  assign m_ttype  = sel ? fp_ttype  : rr_ttype;
  assign m_tsize  = sel ? fp_tsize  : rr_tsize;

  dual_master_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(4)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .i_breq(rr_ireq), .i_ttype(i_ttype), .i_tsize(i_tsize), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(rr_ir), .i_bdone(rr_ib),
    .d_breq(rr_dreq), .d_ttype(d_ttype), .d_tsize(d_tsize), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(rr_dr), .d_bdone(rr_db),
    .s_bstart(rr_bstart), .s_breq(rr_breq), .s_ttype(rr_ttype), .s_tsize(rr_tsize),
    .s_addr(rr_addr), .s_wdata(rr_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone),
    .timeout_err(rr_to));

  dual_master_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(4)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .i_breq(fp_ireq), .i_ttype(i_ttype), .i_tsize(i_tsize), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(fp_ir), .i_bdone(fp_ib),
    .d_breq(fp_dreq), .d_ttype(d_ttype), .d_tsize(d_tsize), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(fp_dr), .d_bdone(fp_db),
    .s_bstart(fp_bstart), .s_breq(fp_breq), .s_ttype(fp_ttype), .s_tsize(fp_tsize),
    .s_addr(fp_addr), .s_wdata(fp_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone),
    .timeout_err(fp_to));

  typedef struct { bit is_d; bit to; int k; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_total = 0, n_bad = 0;
  int cyc = 0, last_done_cyc = 0, t0 = 0;
  int slv_lat = 1, slv_cnt = 0;
  bit slv_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_addr(input bit is_d, input int k);
    return (is_d ? 32'h2000 : 32'h0100) + 32'(k * 16);
  endfunction
  function automatic ttype_e f_tt(input bit is_d, input int k);
    if (is_d) return (k % 2 == 0) ? WRITE : READ;
    return (k % 3 == 2) ? WRITE : READ;
  endfunction
  function automatic tsize_e f_ts(input bit is_d, input int k);
    if (is_d) return tsize_e'(2'(k % 3));
    return WORD;
  endfunction

  task automatic push(input bit is_d, input int k, input bit to);
    exp_t e;
    e.is_d = is_d; e.to = to; e.k = k;
    sb.push_back(e);
  endtask

  // Issues n back-to-back transfers, holding fields until this master's bdone.
  task automatic run_master(input bit is_d, input int k0, input int n);
    int waited;
    bit seen;
    for (int k = k0; k < k0 + n; k++) begin
      if (is_d) begin
        d_breq = 1'b1; d_addr = f_addr(1, k); d_ttype = f_tt(1, k);
        d_tsize = f_ts(1, k); d_wdata = f_addr(1, k) ^ 32'h5A5A5A5A;
      end else begin
        i_breq = 1'b1; i_addr = f_addr(0, k); i_ttype = f_tt(0, k);
        i_tsize = f_ts(0, k); i_wdata = f_addr(0, k) ^ 32'h5A5A5A5A;
      end
      waited = 0;
      seen = 1'b0;
      while (!seen && waited < 40) begin
        @(negedge clk);
        seen = is_d ? m_db : m_ib;
        waited++;
      end
      if (!seen) check(is_d ? "d_bdone_wait" : "i_bdone_wait", 0, 1);
      @(posedge clk); #1;
    end
    if (is_d) d_breq = 1'b0;
    else i_breq = 1'b0;
  endtask

  task automatic tie_after_d(input bit i_first, input int k);
    push(1, k, 0);
    run_master(1, k, 1);
    if (i_first) begin push(0, k, 0); push(1, k + 1, 0); end
    else begin push(1, k + 1, 0); push(0, k, 0); end
    fork
      run_master(1, k + 1, 1);
      run_master(0, k, 1);
    join
  endtask

  task automatic idle_bdone_pulse(input string tag);
    slv_en = 1'b0;
    s_bdone = 1'b1;
    s_rdata = 32'h1234_5678;
    @(negedge clk);
    check({tag, "_i_bdone"}, 32'(m_ib), 0);
    check({tag, "_d_bdone"}, 32'(m_db), 0);
    check({tag, "_bstart"}, 32'(m_bstart), 0);
    @(posedge clk); #1;
    s_bdone = 1'b0;
    check({tag, "_bstart_next"}, 32'(m_bstart), 0);
    slv_en = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL hang: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Slave model: completes slv_lat cycles after the first owned cycle; -1 never completes.
  initial forever begin
    @(posedge clk); #1;
    if (slv_en) begin
      if (!m_bstart) slv_cnt = 0;
      else if (slv_cnt == 0 || s_bdone) slv_cnt = 1;
      else slv_cnt++;
      s_bdone = m_bstart && (slv_lat >= 0) && (slv_cnt == slv_lat + 1);
      s_rdata = s_bdone ? (m_addr ^ RKEY) : 32'hBAD0_BAD0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_ib || m_db) begin
      last_done_cyc = cyc;
      check("bdone_onehot", 32'(m_ib & m_db), 0);
      if (sb.size() == 0) begin
        check("unexpected_bdone", 32'(sb.size()), 1);
      end else begin
        mon_e = sb.pop_front();
        check("owner", 32'(m_db), 32'(mon_e.is_d));
        check("s_breq", 32'(m_breq), 1);
        check("s_addr", m_addr, f_addr(mon_e.is_d, mon_e.k));
        check("s_ttype", 32'(m_ttype), 32'(f_tt(mon_e.is_d, mon_e.k)));
        check("s_tsize", 32'(m_tsize), 32'(f_ts(mon_e.is_d, mon_e.k)));
        check("s_wdata", m_wdata, f_addr(mon_e.is_d, mon_e.k) ^ 32'h5A5A5A5A);
        check("rdata", mon_e.is_d ? m_dr : m_ir,
              mon_e.to ? 32'h0 : (f_addr(mon_e.is_d, mon_e.k) ^ RKEY));
        check("timeout_err", 32'(m_to), 32'(mon_e.to));
      end
    end else begin
      check("timeout_err_quiet", 32'(m_to), 0);
    end
    if (!m_ib) check("i_rdata_quiet", m_ir, 0);
    if (!m_db) check("d_rdata_quiet", m_dr, 0);
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; s_bdone = 1'b0; s_rdata = '0;
    i_breq = 1'b0; i_ttype = READ; i_tsize = WORD; i_addr = '0; i_wdata = '0;
    d_breq = 1'b0; d_ttype = READ; d_tsize = WORD; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bstart", 32'(m_bstart), 0);
    check("rst_breq", 32'(m_breq), 0);
    check("rst_ttype", 32'(m_ttype), 32'(READ));
    check("rst_tsize", 32'(m_tsize), 32'(WORD));
    check("rst_addr", m_addr, 0);
    check("rst_fp_bstart", 32'(fp_bstart), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    idle_bdone_pulse("idle");

    slv_lat = 2;
    push(0, 0, 0);
    t0 = cyc;
    run_master(0, 0, 1);
    check("single_i_latency", 32'(last_done_cyc - t0), 3);

    slv_lat = 1;
    for (int k = 0; k < 3; k++) begin
      push(1, k, 0);
      push(0, k, 0);
    end
    t0 = cyc;
    fork
      run_master(1, 0, 3);
      run_master(0, 0, 3);
    join
    check("rr_zero_bubble_span", 32'(last_done_cyc - t0), 12);
    tie_after_d(1'b1, 3);

    slv_lat = -1;
    push(0, 5, 1);
    t0 = cyc;
    run_master(0, 5, 1);
    check("timeout_latency", 32'(last_done_cyc - t0), 4);
    check("timeout_release", 32'(m_bstart), 0);
    idle_bdone_pulse("late");

    sel = 1'b1;
    slv_lat = 1;
    tie_after_d(1'b0, 8);
    push(1, 10, 0); push(0, 10, 0); push(1, 11, 0);
    fork
      run_master(1, 10, 2);
      run_master(0, 10, 1);
    join

    slv_lat = -1;
    d_breq = 1'b1; d_addr = f_addr(1, 12); d_ttype = f_tt(1, 12);
    d_tsize = f_ts(1, 12); d_wdata = f_addr(1, 12) ^ 32'h5A5A5A5A;
    @(posedge clk); #1;
    check("pre_reset_bstart", 32'(m_bstart), 1);
    rst_n = 1'b0;
    d_breq = 1'b0;
    #1;
    check("reset_bstart", 32'(m_bstart), 0);
    check("reset_d_bdone", 32'(m_db), 0);
    check("reset_addr", m_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    slv_lat = 1;
    push(1, 13, 0);
    t0 = cyc;
    run_master(1, 13, 1);
    check("post_reset_latency", 32'(last_done_cyc - t0), 2);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
